// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Optional glitch filter on PS2_CLK is selected with PS2_GLITCH_FILTER_EN.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    // bits[7:0] data, bits[8] parity, bits[9] stop
    function automatic logic frame_ok(input logic [9:0] bits);
        return (^bits[8:0]) & bits[9];
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO with registered storage and combinational head read.
// Simultaneous push and pop while full are both accepted.
module ps2_event_fifo #(
    parameter int unsigned Depth = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_en_i,
    input  logic [9:0] wr_data_i,
    input  logic       rd_en_i,
    output logic [9:0] rd_data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [9:0]    mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_ok, rd_ok;

    assign full_o    = (count_q == (AW+1)'(Depth));
    assign empty_o   = (count_q == '0);
    assign rd_ok     = rd_en_i & ~empty_o;
    assign wr_ok     = wr_en_i & (~full_o | rd_ok);
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, folds E0/F0 prefixes into
// key events and queues them. Define PS2_GLITCH_FILTER_EN to filter PS2_CLK.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 6000,
    parameter int unsigned FILT_CYCLES    = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic clk_level, clk_prev_q, fall;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= PS2_CLK;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= PS2_DAT;
            dat_sync_q <= dat_meta_q;
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    localparam int unsigned FiltW = $clog2(FILT_CYCLES + 1);

    logic             filt_q, filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;

    // Counts consecutive samples that disagree with the accepted level.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FiltW'(FILT_CYCLES - 1)) begin
                filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign clk_level = filt_q;
`else
    logic unused_filt;
    assign unused_filt = ^FILT_CYCLES;
    assign clk_level   = clk_sync_q;
`endif

    assign fall = clk_prev_q & ~clk_level;

    ps2_state_e    state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          frame_err_q, overflow_q, overflow_d;
    logic          timeout, push, err;
    key_event_t    push_ev, head_ev;
    logic [9:0]    head_raw;
    logic          fifo_full, fifo_empty, pop;

    assign timeout = (tmo_q == TmoW'(TIMEOUT_CYCLES));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            clk_prev_q  <= 1'b1;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_prev_q  <= clk_level;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            frame_err_q <= err;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fall && !dat_sync_q) state_d = RECV;
            RECV: begin
                if (fall && bitcnt_q == 4'd10) state_d = CHECK;
                else if (!fall && timeout)     state_d = IDLE;
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        tmo_d    = tmo_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        push     = 1'b0;
        err      = 1'b0;
        push_ev  = '{ext: ext_q, brk: brk_q, code: shift_q[7:0]};
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (fall) begin
                    if (!dat_sync_q) bitcnt_d = 4'd1;
                    else             err      = 1'b1;
                end
            end
            RECV: begin
                if (fall) begin
                    shift_d  = {dat_sync_q, shift_q[9:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    tmo_d    = '0;
                end else if (timeout) begin
                    err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                if (!frame_ok(shift_q)) begin
                    err   = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else if (shift_q[7:0] == PS2_EXT_PREFIX) begin
                    ext_d = 1'b1;
                end else if (shift_q[7:0] == PS2_BREAK_PREFIX) begin
                    brk_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign pop        = key_valid & key_ready;
    assign overflow_d = overflow_q | (push & fifo_full & ~pop);

    ps2_event_fifo #(
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (CLOCK_50),
        .rst_i    (reset),
        .wr_en_i  (push),
        .wr_data_i(push_ev),
        .rd_en_i  (pop),
        .rd_data_o(head_raw),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    assign head_ev   = key_event_t'(head_raw);
    assign key_valid = ~fifo_empty;
    // Head fields are masked so the outputs read zero while nothing is queued.
    assign key_code  = key_valid ? head_ev.code : 8'h00;
    assign key_ext   = key_valid & head_ev.ext;
    assign key_break = key_valid & head_ev.brk;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed self-checking bench for ps2_keyboard_rx.
module tb_ps2_keyboard_rx;

    logic       CLOCK_50 = 1'b0;
    logic       reset, PS2_CLK, PS2_DAT, key_ready;
    logic       key_valid, key_ext, key_break, frame_err, overflow;
    logic [7:0] key_code;

    int         n_cmp = 0, n_bad = 0;
    int         err_cyc = 0, err_rise = 0;
    logic       err_prev = 1'b0;
    logic [9:0] evq[$];

    ps2_keyboard_rx dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .PS2_CLK  (PS2_CLK),
        .PS2_DAT  (PS2_DAT),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_code (key_code),
        .key_ext  (key_ext),
        .key_break(key_break),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (frame_err) err_cyc <= err_cyc + 1;
        if (frame_err && !err_prev) err_rise <= err_rise + 1;
        err_prev <= frame_err;
        if (key_valid && key_ready) evq.push_back({key_ext, key_break, key_code});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Sends the first nbits of a frame (start, 8 data LSB first, odd parity, stop).
    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int half,
                             input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = fr[i];
            cyc(half);
            PS2_CLK = 1'b0;
            cyc(half);
            PS2_CLK = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b0, 20, 11);
        cyc(20);
    endtask

    task automatic test_reset;
        reset = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1; key_ready = 1'b1;
        cyc(4);
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", key_valid); end
        n_cmp++; if (key_code !== 8'h00) begin n_bad++; $display("FAIL rst_code: got %h want 00", key_code); end
        n_cmp++; if ({key_ext, key_break} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %b want 00", {key_ext, key_break}); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", frame_err); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        reset = 1'b0;
        cyc(5);
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid: got %b want 0", key_valid); end
    endtask

    // 0x1C at 12.5 kHz; raw fall -> 2 sync cycles -> detect N -> push N+1 -> valid N+2.
    task automatic test_single_slow;
        int e0;
        e0 = err_rise; evq.delete();
        send_bits(8'h1C, 1'b0, 2000, 10);
        PS2_DAT = 1'b1;
        cyc(2000);
        PS2_CLK = 1'b0;
        cyc(3);
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early: got %b want 0", key_valid); end
        cyc(1);
        n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid: got %b want 1", key_valid); end
        n_cmp++; if ({key_ext, key_break, key_code} !== 10'h01C) begin n_bad++; $display("FAIL lat_head: got %h want 01c", {key_ext, key_break, key_code}); end
        cyc(2000);
        PS2_CLK = 1'b1;
        cyc(20);
        n_cmp++; if (evq.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", evq.size()); end
        else begin
            n_cmp++; if (evq[0] !== 10'h01C) begin n_bad++; $display("FAIL single_event: got %h want 01c", evq[0]); end
        end
        n_cmp++; if (err_rise - e0 !== 0) begin n_bad++; $display("FAIL single_err: got %0d want 0", err_rise - e0); end
    endtask

    task automatic test_prefix;
        evq.delete();
        send_frame(8'hE0);
        send_frame(8'hF0);
        n_cmp++; if (evq.size() !== 0) begin n_bad++; $display("FAIL prefix_silent: got %0d want 0", evq.size()); end
        send_frame(8'h75);
        n_cmp++; if (evq.size() !== 1) begin n_bad++; $display("FAIL prefix_count: got %0d want 1", evq.size()); end
        else begin
            n_cmp++; if (evq[0] !== 10'h375) begin n_bad++; $display("FAIL prefix_event: got %h want 375", evq[0]); end
        end
    endtask

    task automatic test_parity;
        int e0, c0;
        e0 = err_rise; c0 = err_cyc; evq.delete();
        send_bits(8'h1C, 1'b1, 20, 11);
        cyc(20);
        n_cmp++; if (err_rise - e0 !== 1) begin n_bad++; $display("FAIL par_err: got %0d want 1", err_rise - e0); end
        n_cmp++; if (err_cyc - c0 !== 1) begin n_bad++; $display("FAIL par_width: got %0d want 1", err_cyc - c0); end
        n_cmp++; if (evq.size() !== 0) begin n_bad++; $display("FAIL par_noevent: got %0d want 0", evq.size()); end
        send_frame(8'h32);
        n_cmp++; if (evq.size() !== 1 || evq[0] !== 10'h032) begin n_bad++; $display("FAIL par_next: got n=%0d ev=%h want 1/032", evq.size(), (evq.size() > 0) ? evq[0] : 10'h3FF); end
    endtask

    task automatic test_timeout;
        int e0, c0;
        e0 = err_rise; c0 = err_cyc; evq.delete();
        send_bits(8'h4D, 1'b0, 20, 5);
        cyc(5900);
        n_cmp++; if (err_rise - e0 !== 0) begin n_bad++; $display("FAIL tmo_early: got %0d want 0", err_rise - e0); end
        cyc(200);
        n_cmp++; if (err_rise - e0 !== 1) begin n_bad++; $display("FAIL tmo_err: got %0d want 1", err_rise - e0); end
        n_cmp++; if (err_cyc - c0 !== 1) begin n_bad++; $display("FAIL tmo_width: got %0d want 1", err_cyc - c0); end
        send_frame(8'h4D);
        n_cmp++; if (evq.size() !== 1 || evq[0] !== 10'h04D) begin n_bad++; $display("FAIL tmo_next: got n=%0d ev=%h want 1/04d", evq.size(), (evq.size() > 0) ? evq[0] : 10'h3FF); end
    endtask

    task automatic test_overflow;
        logic [7:0] codes [9];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        evq.delete();
        key_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send_frame(codes[i]);
            n_cmp++; if (key_code !== 8'h15) begin n_bad++; $display("FAIL ovf_hold%0d: got %h want 15", i, key_code); end
        end
        n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid: got %b want 1", key_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        key_ready = 1'b1;
        cyc(20);
        n_cmp++; if (evq.size() !== 8) begin n_bad++; $display("FAIL ovf_count: got %0d want 8", evq.size()); end
        for (int i = 0; i < 8 && i < evq.size(); i++) begin
            n_cmp++; if (evq[i] !== {2'b00, codes[i]}) begin n_bad++; $display("FAIL ovf_order%0d: got %h want %h", i, evq[i], {2'b00, codes[i]}); end
        end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", key_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_mid;
        int e0;
        e0 = err_rise; evq.delete();
        send_bits(8'h29, 1'b0, 20, 4);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(3);
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_ovf: got %b want 0", overflow); end
        send_frame(8'h29);
        n_cmp++; if (err_rise - e0 !== 0) begin n_bad++; $display("FAIL mid_err: got %0d want 0", err_rise - e0); end
        n_cmp++; if (evq.size() !== 1 || evq[0] !== 10'h029) begin n_bad++; $display("FAIL mid_event: got n=%0d ev=%h want 1/029", evq.size(), (evq.size() > 0) ? evq[0] : 10'h3FF); end
    endtask

    initial begin
        test_reset();
        test_single_slow();
        test_prefix();
        test_parity();
        test_timeout();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
